// File: rtl/wbucodarb.sv
`default_nettype none
// ============================================================================
//  Module   : wbucodarb
//  Purpose  : Three-source round-robin codeword arbiter feeding a one-word
//             output register. Optional burst locking is enabled by defining
//             WBUCODARB_BURST_EN.
//  Revision : 1.0
// ============================================================================
module wbucodarb #(
    parameter int BURST_LEN = 4
) (
    input  logic        i_clk,
    input  logic        i_areset_n,
    input  logic        i_stb_0,
    input  logic        i_stb_1,
    input  logic        i_stb_2,
    input  logic [35:0] i_word_0,
    input  logic [35:0] i_word_1,
    input  logic [35:0] i_word_2,
    output logic        o_busy_0,
    output logic        o_busy_1,
    output logic        o_busy_2,
    output logic        o_stb,
    output logic [35:0] o_codword,
    output logic [1:0]  o_src,
    input  logic        i_tx_busy
);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    if (BURST_LEN < 1 || BURST_LEN > 15) begin : g_bad_burst_len
        $error("wbucodarb: BURST_LEN out of range 1..15");
    end

    logic [0:0]  r_state;
    logic [35:0] r_codword;
    logic [1:0]  r_src;
    logic [2:0]  w_stb;
    logic        w_grant_valid;
    logic [1:0]  w_grant_idx;
    logic [35:0] w_grant_word;
    logic        w_xfer;

    assign w_stb = {i_stb_2, i_stb_1, i_stb_0};

    function automatic logic [1:0] rr_idx(input logic [1:0] last, input int off);
        return 2'((int'(last) + 1 + off) % 3);
    endfunction

`ifdef WBUCODARB_BURST_EN
    localparam logic [3:0] c_BURST_LEN = 4'(BURST_LEN);
    logic       r_lock;
    logic [3:0] r_count;
    logic       w_lock_hit;

    assign w_lock_hit = r_lock && (r_count < c_BURST_LEN) && w_stb[r_src];
`endif

    // Scan from the lowest priority upward so the highest-priority hit wins.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = 2'd0;
        for (int i = 2; i >= 0; i--) begin
            if (w_stb[rr_idx(r_src, i)]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = rr_idx(r_src, i);
            end
        end
`ifdef WBUCODARB_BURST_EN
        if (w_lock_hit) begin
            w_grant_valid = 1'b1;
            w_grant_idx   = r_src;
        end
`endif
    end

    always_comb begin
        case (w_grant_idx)
            2'd0:    w_grant_word = i_word_0;
            2'd1:    w_grant_word = i_word_1;
            default: w_grant_word = i_word_2;
        endcase
    end

    assign w_xfer   = (r_state == S_EMPTY) && w_grant_valid;
    assign o_busy_0 = !(w_xfer && (w_grant_idx == 2'd0));
    assign o_busy_1 = !(w_xfer && (w_grant_idx == 2'd1));
    assign o_busy_2 = !(w_xfer && (w_grant_idx == 2'd2));

    // A FULL cycle never reloads, which forces the one-clock gap between words.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_state   <= S_EMPTY;
            r_codword <= 36'h0;
            r_src     <= 2'd2;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_xfer) begin
                        r_codword <= w_grant_word;
                        r_src     <= w_grant_idx;
                        r_state   <= S_FULL;
                    end
                end
                default: begin
                    if (!i_tx_busy) begin
                        r_state <= S_EMPTY;
                    end
                end
            endcase
        end
    end

`ifdef WBUCODARB_BURST_EN
    // Lock drops as soon as the burst budget is spent so round-robin resumes.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_lock  <= 1'b0;
            r_count <= 4'd0;
        end else if (r_state == S_EMPTY) begin
            if (w_xfer && w_lock_hit) begin
                r_count <= r_count + 4'd1;
                r_lock  <= (r_count + 4'd1) < c_BURST_LEN;
            end else if (w_xfer) begin
                r_count <= 4'd1;
                r_lock  <= c_BURST_LEN > 4'd1;
            end else if (r_lock && !w_stb[r_src]) begin
                r_lock  <= 1'b0;
            end
        end
    end
`endif

    assign o_stb     = (r_state == S_FULL);
    assign o_codword = r_codword;
    assign o_src     = r_src;

endmodule
`default_nettype wire

// File: doc/wbucodarb.md
WBUCODARB -- requirements
Module: wbucodarb

Interface
REQ-001 SHALL provide parameter BURST_LEN, default 4, range 1..15: maximum consecutive words one source may send while holding burst lock.
REQ-002 SHALL have port i_clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port i_areset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports i_stb_0/1/2, input, 1 each: source k has a codeword pending.
REQ-005 SHALL have ports i_word_0/1/2, input, 36 each: source k codeword, stable while i_stb_k is high.
REQ-006 SHALL have ports o_busy_0/1/2, output, 1 each: source k may not transfer this cycle.
REQ-007 SHALL have port o_stb, output, 1: codeword valid to the idle/interrupt insertion stage.
REQ-008 SHALL have port o_codword, output, 36: registered codeword.
REQ-009 SHALL have port o_src, output, 2: index of the source that supplied o_codword.
REQ-010 SHALL have port i_tx_busy, input, 1: downstream cannot accept this cycle.

Function
REQ-011 SHALL transfer a word from source k in any cycle where i_stb_k is high and o_busy_k is low.
REQ-012 SHALL complete a downstream transfer in any cycle where o_stb is high and i_tx_busy is low.
REQ-013 SHALL implement two states: EMPTY (o_stb=0) and FULL (o_stb=1).
REQ-014 SHALL, in EMPTY, select at most one winner combinationally and drive o_busy_winner=0; all other o_busy_k SHALL be 1.
REQ-015 SHALL drive all o_busy_k=1 while in FULL.
REQ-016 SHALL, on a source transfer in EMPTY, register the word into o_codword, the winner index into o_src, and go to FULL; latency is 1 clock.
REQ-017 SHALL, in FULL, hold o_stb, o_codword and o_src unchanged while i_tx_busy is 1.
REQ-018 SHALL, in FULL with i_tx_busy=0, return to EMPTY on the next edge and SHALL NOT load a new word in that same cycle.
REQ-019 SHALL therefore insert a minimum one-clock gap between words, giving peak throughput of one word per two clocks.
REQ-020 SHALL select the winner round-robin: the search starts at (last+1) mod 3 and takes the first source with i_stb set; last is the o_src of the most recent grant.
REQ-021 SHALL keep o_codword unchanged and grant nothing in EMPTY when no i_stb_k is set.
REQ-022 SHALL keep o_busy_k combinational from state, lock and i_stb only, with no dependence on i_tx_busy.
REQ-023 SHALL never return o_src=3.

Reset
REQ-024 SHALL, while i_areset_n=0 and independent of i_clk, force o_stb=0, o_codword=36'h0, o_src=2, last=2, burst count=0 and lock=0.
REQ-025 SHALL make source 0 the highest priority for the first grant after reset.
REQ-026 SHALL discard a word held in FULL when reset is asserted mid-transfer; no partial state survives.

Configuration
REQ-027 SHALL compile burst locking in only when macro WBUCODARB_BURST_EN is defined.
REQ-028 SHALL, with WBUCODARB_BURST_EN defined, set lock and burst count=1 on a grant to a new source; each further grant to the locked source SHALL increment the count.
REQ-029 SHALL, with the macro defined, in EMPTY with lock set, i_stb_last=1 and count<BURST_LEN, grant last regardless of round-robin order.
REQ-030 SHALL, with the macro defined, clear lock when count reaches BURST_LEN or when i_stb_last=0 in EMPTY; round-robin from last+1 then applies.
REQ-031 SHALL, without WBUCODARB_BURST_EN, apply pure round-robin on every word; the lock and count registers SHALL be absent and BURST_LEN ignored.

Verification
REQ-032 SHALL verify: reset, then i_stb_0/1/2 all high with words A0,B1,C2 and i_tx_busy=0 -> o_src sequence 0,1,2,0; o_stb high one clock of every two.
REQ-033 SHALL verify: a word accepted while i_tx_busy is held high 5 clocks -> o_codword/o_src constant for 5 clocks, all o_busy_k=1, and EMPTY one clock after i_tx_busy falls.
REQ-034 SHALL verify, with the macro defined and BURST_LEN=4: sources 0 and 1 both always requesting -> o_src 0,0,0,0,1,1,1,1,0.
REQ-035 SHALL verify the same stimulus without the macro -> o_src 0,1,0,1,...
REQ-036 SHALL verify: i_areset_n pulsed low mid-FULL, asynchronously to i_clk -> o_stb=0 immediately; first grant afterward goes to source 0.
REQ-037 SHALL verify: only source 2 requesting, word 36'h4_0000_0000 -> delivered unchanged with o_src=2; o_busy_0 and o_busy_1 remain 1.
